// File: rtl/pc_sequencer.sv
// Program counter sequencer: starts a program on req, steps the ROM address with
// stall/halt/branch priority, flags running off the end of the ROM, counts RUN cycles.
module pc_sequencer #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             halt,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             stall,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             running,
  output logic             done,
  output logic             pc_err,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  PC_START = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0]  PC_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_START;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALTED: begin
        if (req) begin
          state_d = RUN;
          pc_d    = PC_START;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        // Every RUN edge counts, stalled and halting edges included.
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (stall) begin
          pc_d = pc_q;
        end else if (halt) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end else if (branch_taken) begin
          pc_d = branch_target;
        end else if (pc_q == PC_MAX) begin
          // Falling off the ROM end stops the program instead of wrapping.
          state_d = HALTED;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d == RUN);
  end

  assign prog_ctr    = pc_q;
  assign running     = run_q;
  assign done        = done_q;
  assign pc_err      = err_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: per-scenario stimulus tables with hand-derived
// expected outputs queued at drive time and popped after each edge.
module tb_pc_sequencer;
  localparam int PC_W  = 10;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req = 1'b0, halt = 1'b0, branch_taken = 1'b0, stall = 1'b0;
  logic [PC_W-1:0]  branch_target = '0;
  logic [PC_W-1:0]  prog_ctr;
  logic             running, done, pc_err;
  logic [CNT_W-1:0] cycle_count;

  pc_sequencer #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .halt(halt), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall(stall), .prog_ctr(prog_ctr), .running(running),
    .done(done), .pc_err(pc_err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             run;
    logic             dn;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic            rq;
    logic            hl;
    logic            br;
    logic [PC_W-1:0] tgt;
    logic            st;
    exp_t            e;
  } row_t;

  row_t rows[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic exp_t ex(int pc, bit run, bit dn, bit err, int cnt);
    exp_t r;
    r.pc  = PC_W'(pc);
    r.run = run;
    r.dn  = dn;
    r.err = err;
    r.cnt = CNT_W'(cnt);
    return r;
  endfunction

  function automatic row_t rw(bit rq, bit hl, bit br, int tgt, bit st, exp_t e);
    row_t r;
    r.rq  = rq;
    r.hl  = hl;
    r.br  = br;
    r.tgt = PC_W'(tgt);
    r.st  = st;
    r.e   = e;
    return r;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.pc  = prog_ctr;
    o.run = running;
    o.dn  = done;
    o.err = pc_err;
    o.cnt = cycle_count;
    return o;
  endfunction

  task automatic cyc(input row_t r);
    req           = r.rq;
    halt          = r.hl;
    branch_taken  = r.br;
    branch_target = r.tgt;
    stall         = r.st;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    #2;
    sb.push_back(ex(0, 0, 0, 0, 0));
    e = sb.pop_front(); o = obs(); n_chk++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_async: got pc=%h run=%b done=%b err=%b cnt=%0d, want pc=%h run=%b done=%b err=%b cnt=%0d",
               o.pc, o.run, o.dn, o.err, o.cnt, e.pc, e.run, e.dn, e.err, e.cnt);
    end
    // req while reset is held must not start anything
    sb.push_back(ex(0, 0, 0, 0, 0));
    cyc(rw(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0)));
    e = sb.pop_front(); o = obs(); n_chk++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_held_req: got pc=%h run=%b done=%b err=%b cnt=%0d, want pc=%h run=%b done=%b err=%b cnt=%0d",
               o.pc, o.run, o.dn, o.err, o.cnt, e.pc, e.run, e.dn, e.err, e.cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    rows.delete();
    rows.push_back(rw(1, 0, 0, 0, 0, ex(0, 1, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, ex(1, 1, 0, 0, 1)));
    rows.push_back(rw(0, 1, 0, 0, 0, ex(1, 0, 1, 0, 2)));
    foreach (rows[i]) begin
      sb.push_back(rows[i].e);
      cyc(rows[i]);
      e = sb.pop_front(); o = obs(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_first_req[%0d]: got pc=%h run=%b done=%b err=%b cnt=%0d, want pc=%h run=%b done=%b err=%b cnt=%0d",
                 i, o.pc, o.run, o.dn, o.err, o.cnt, e.pc, e.run, e.dn, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_straight_line();
    exp_t e, o;
    rows.delete();
    rows.push_back(rw(1, 0, 0, 0, 0, ex(0, 1, 0, 0, 0)));
    // req raised mid-run (pc 2 -> 3) is ignored
    for (int k = 1; k <= 5; k++) rows.push_back(rw(k == 3, 0, 0, 0, 0, ex(k, 1, 0, 0, k)));
    rows.push_back(rw(0, 1, 0, 0, 0, ex(5, 0, 1, 0, 6)));
    rows.push_back(rw(0, 0, 0, 0, 0, ex(5, 0, 1, 0, 6)));
    rows.push_back(rw(0, 1, 1, 9, 0, ex(5, 0, 1, 0, 6)));
    foreach (rows[i]) begin
      sb.push_back(rows[i].e);
      cyc(rows[i]);
      e = sb.pop_front(); o = obs(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL straight_line[%0d]: got pc=%h run=%b done=%b err=%b cnt=%0d, want pc=%h run=%b done=%b err=%b cnt=%0d",
                 i, o.pc, o.run, o.dn, o.err, o.cnt, e.pc, e.run, e.dn, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_branch_stall();
    exp_t e, o;
    rows.delete();
    rows.push_back(rw(1, 0, 0, 0,     0, ex(0,     1, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0,     0, ex(1,     1, 0, 0, 1)));
    rows.push_back(rw(0, 0, 0, 0,     0, ex(2,     1, 0, 0, 2)));
    rows.push_back(rw(0, 0, 1, 'h100, 0, ex('h100, 1, 0, 0, 3)));
    rows.push_back(rw(0, 0, 1, 'h055, 1, ex('h100, 1, 0, 0, 4)));
    rows.push_back(rw(0, 0, 0, 0,     1, ex('h100, 1, 0, 0, 5)));
    rows.push_back(rw(0, 0, 0, 0,     1, ex('h100, 1, 0, 0, 6)));
    rows.push_back(rw(0, 0, 0, 0,     0, ex('h101, 1, 0, 0, 7)));
    foreach (rows[i]) begin
      sb.push_back(rows[i].e);
      cyc(rows[i]);
      e = sb.pop_front(); o = obs(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL branch_stall[%0d]: got pc=%h run=%b done=%b err=%b cnt=%0d, want pc=%h run=%b done=%b err=%b cnt=%0d",
                 i, o.pc, o.run, o.dn, o.err, o.cnt, e.pc, e.run, e.dn, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_halt_during_stall();
    exp_t e, o;
    rows.delete();
    rows.push_back(rw(0, 1, 0, 0,     1, ex('h101, 1, 0, 0, 8)));
    rows.push_back(rw(0, 1, 1, 'h200, 1, ex('h101, 1, 0, 0, 9)));
    rows.push_back(rw(0, 1, 1, 'h200, 0, ex('h101, 0, 1, 0, 10)));
    rows.push_back(rw(0, 0, 0, 0,     0, ex('h101, 0, 1, 0, 10)));
    foreach (rows[i]) begin
      sb.push_back(rows[i].e);
      cyc(rows[i]);
      e = sb.pop_front(); o = obs(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL halt_during_stall[%0d]: got pc=%h run=%b done=%b err=%b cnt=%0d, want pc=%h run=%b done=%b err=%b cnt=%0d",
                 i, o.pc, o.run, o.dn, o.err, o.cnt, e.pc, e.run, e.dn, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e, o;
    rows.delete();
    rows.push_back(rw(1, 0, 0, 0,     0, ex(0,     1, 0, 0, 0)));
    rows.push_back(rw(0, 0, 1, 'h3FF, 0, ex('h3FF, 1, 0, 0, 1)));
    rows.push_back(rw(0, 0, 0, 0,     0, ex('h3FF, 0, 1, 1, 2)));
    rows.push_back(rw(0, 0, 0, 0,     0, ex('h3FF, 0, 1, 1, 2)));
    rows.push_back(rw(1, 0, 0, 0,     0, ex(0,     1, 0, 0, 0)));
    rows.push_back(rw(0, 0, 1, 'h3FF, 0, ex('h3FF, 1, 0, 0, 1)));
    rows.push_back(rw(0, 0, 1, 'h3FF, 0, ex('h3FF, 1, 0, 0, 2)));
    rows.push_back(rw(0, 0, 1, 'h010, 0, ex('h010, 1, 0, 0, 3)));
    rows.push_back(rw(0, 1, 0, 0,     0, ex('h010, 0, 1, 0, 4)));
    foreach (rows[i]) begin
      sb.push_back(rows[i].e);
      cyc(rows[i]);
      e = sb.pop_front(); o = obs(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL overflow[%0d]: got pc=%h run=%b done=%b err=%b cnt=%0d, want pc=%h run=%b done=%b err=%b cnt=%0d",
                 i, o.pc, o.run, o.dn, o.err, o.cnt, e.pc, e.run, e.dn, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e, o;
    rows.delete();
    rows.push_back(rw(1, 0, 0, 0, 0, ex(0, 1, 0, 0, 0)));
    for (int k = 1; k <= 7; k++) rows.push_back(rw(0, 0, 0, 0, 0, ex(k, 1, 0, 0, k)));
    foreach (rows[i]) begin
      sb.push_back(rows[i].e);
      cyc(rows[i]);
      e = sb.pop_front(); o = obs(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_run_pre[%0d]: got pc=%h run=%b done=%b err=%b cnt=%0d, want pc=%h run=%b done=%b err=%b cnt=%0d",
                 i, o.pc, o.run, o.dn, o.err, o.cnt, e.pc, e.run, e.dn, e.err, e.cnt);
      end
    end
    #3;
    reset = 1'b1;
    sb.push_back(ex(0, 0, 0, 0, 0));
    #1;
    e = sb.pop_front(); o = obs(); n_chk++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_mid_run_async: got pc=%h run=%b done=%b err=%b cnt=%0d, want pc=%h run=%b done=%b err=%b cnt=%0d",
               o.pc, o.run, o.dn, o.err, o.cnt, e.pc, e.run, e.dn, e.err, e.cnt);
    end
    #2;
    @(negedge clk);
    reset = 1'b0;
    rows.delete();
    rows.push_back(rw(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0)));
    rows.push_back(rw(1, 0, 0, 0, 0, ex(0, 1, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, ex(1, 1, 0, 0, 1)));
    foreach (rows[i]) begin
      sb.push_back(rows[i].e);
      cyc(rows[i]);
      e = sb.pop_front(); o = obs(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_run_post[%0d]: got pc=%h run=%b done=%b err=%b cnt=%0d, want pc=%h run=%b done=%b err=%b cnt=%0d",
                 i, o.pc, o.run, o.dn, o.err, o.cnt, e.pc, e.run, e.dn, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e, o;
    rows.delete();
    rows.push_back(rw(0, 1, 0, 0, 0, ex(1, 0, 1, 0, 2)));
    rows.push_back(rw(1, 0, 0, 0, 0, ex(0, 1, 0, 0, 0)));
    for (int k = 1; k <= 20; k++) rows.push_back(rw(0, 0, 0, 0, 0, ex(k, 1, 0, 0, (k > 15) ? 15 : k)));
    rows.push_back(rw(0, 1, 0, 0, 0, ex(20, 0, 1, 0, 15)));
    rows.push_back(rw(0, 0, 0, 0, 0, ex(20, 0, 1, 0, 15)));
    foreach (rows[i]) begin
      sb.push_back(rows[i].e);
      cyc(rows[i]);
      e = sb.pop_front(); o = obs(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got pc=%h run=%b done=%b err=%b cnt=%0d, want pc=%h run=%b done=%b err=%b cnt=%0d",
                 i, o.pc, o.run, o.dn, o.err, o.cnt, e.pc, e.run, e.dn, e.err, e.cnt);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_straight_line();
    test_branch_stall();
    test_halt_during_stall();
    test_overflow();
    test_reset_mid_run();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
